// File: rtl/iterative_div_unit.sv
// -----------------------------------------------------------------------------
// iterative_div_unit
//
// Multi-cycle RV32M divider covering DIV, DIVU, REM and REMU. It sits after
// the register-file read ports and returns a single write-back beat on the
// register-file write port. The datapath is a restoring divider that makes
// one quotient bit per cycle. Control uses a start/busy/done handshake.
//
// Ports
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous, active-low reset
//   start                in   operation request, sampled only in IDLE
//   kill                 in   synchronous abort (pipeline flush), wins over start
//   div_op               in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend             in   rs1 value
//   divisor              in   rs2 value
//   rd_in                in   destination register index
//   busy                 out  high while the unit is in CALC or DONE
//   done                 out  one-cycle result-valid pulse (masked by kill)
//   rd_address           out  rd_in latched at start
//   register_write_en    out  done && rd_address != 0
//   register_write_data  out  result, valid while done is high
// -----------------------------------------------------------------------------
module iterative_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            rd_address,
  output logic                  register_write_en,
  output logic [DATA_WIDTH-1:0] register_write_data
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0]     INT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             is_rem_q, is_rem_d;       // select remainder as the result
  logic             neg_quot_q, neg_quot_d;   // negate quotient at the end
  logic             neg_rem_q, neg_rem_d;     // negate remainder at the end
  logic [4:0]       rd_q, rd_d;
  logic [W-1:0]     dvsr_q, dvsr_d;           // |divisor|
  logic [W-1:0]     quot_q, quot_d;           // |dividend| shifting out, quotient shifting in
  logic [W-1:0]     rem_q, rem_d;             // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------------
  // One restoring step. The partial remainder takes the next dividend bit.
  // The unit then trial-subtracts |divisor| at W+1 bits, so the top bit that
  // was shifted in still takes part in the compare.
  // ---------------------------------------------------------------------------
  logic [W:0]   rem_shift;
  logic [W:0]   trial;
  logic         fits;
  logic [W-1:0] rem_step;
  logic [W-1:0] quot_step;
  logic [W-1:0] quot_fin;
  logic [W-1:0] rem_fin;
  logic         unused_trial_msb;

  assign rem_shift = {rem_q, quot_q[W-1]};
  assign fits      = (rem_shift >= {1'b0, dvsr_q});
  assign trial     = rem_shift - {1'b0, dvsr_q};
  // When the subtract fits, the difference is below |divisor|. When it does
  // not fit, rem_shift is below |divisor|. In both cases the value fits in
  // W bits.
  assign rem_step  = fits ? trial[W-1:0] : rem_shift[W-1:0];
  assign quot_step = {quot_q[W-2:0], fits};
  assign quot_fin  = neg_quot_q ? (~quot_step + 1'b1) : quot_step;
  assign rem_fin   = neg_rem_q  ? (~rem_step  + 1'b1) : rem_step;

  // The top bits are dropped on purpose. The bound above shows they are zero
  // whenever they would be kept.
  assign unused_trial_msb = ^{trial[W], rem_shift[W]};

  // Operand preparation for the start cycle. The signed ops divide magnitudes.
  // The most negative value maps to itself, and read as unsigned that is the
  // correct magnitude.
  logic         op_signed;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_zero, sgn_ovf;

  assign op_signed = ~div_op[0];
  assign a_neg     = op_signed & dividend[W-1];
  assign b_neg     = op_signed & divisor[W-1];
  assign a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag     = b_neg ? (~divisor  + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = op_signed && (dividend == INT_MIN) && (divisor == '1);

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each _d signal gets a hold default first. Then no path through
    // this block leaves a signal unassigned, and no latch is inferred.
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rd_d       = rd_q;
    dvsr_d     = dvsr_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d   = div_op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          rd_d       = rd_in;
          if (div_zero) begin
            // RISC-V: quotient is all ones, remainder is the raw dividend.
            result_d = div_op[1] ? dividend : '1;
            state_d  = S_DONE;
          end else if (sgn_ovf) begin
            // RISC-V: quotient is INT_MIN, remainder is zero.
            result_d = div_op[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            dvsr_d  = b_mag;
            quot_d  = a_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        quot_d = quot_step;
        rem_d  = rem_step;
        if (cnt_q == LAST_CNT) begin
          result_d = is_rem_q ? rem_fin : quot_fin;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // The result cannot stall, so the unit always returns to IDLE.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush overrides everything, including a start in this cycle.
    if (kill) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      dvsr_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register reads values from
      // before the edge no matter how the statements are ordered.
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rd_q       <= rd_d;
      dvsr_q     <= dvsr_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. A kill in the DONE cycle hides that cycle's result.
  // ---------------------------------------------------------------------------
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE) && !kill;
  assign rd_address          = rd_q;
  assign register_write_en   = done && (rd_q != 5'd0);
  assign register_write_data = result_q;

endmodule

// File: tb/tb_iterative_div_unit.sv
// -----------------------------------------------------------------------------
// tb_iterative_div_unit
//
// Directed bench for iterative_div_unit. Each accepted operation pushes its
// hand-computed result onto a queue. The entry also holds the cycle in which
// done must appear. An independent monitor pops the queue and compares on
// every done pulse.
// -----------------------------------------------------------------------------
module tb_iterative_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int LAT_NORMAL  = 32;  // start edge N -> done after edge N+32
  localparam int LAT_SPECIAL = 0;   // start edge N -> done after edge N

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [4:0]  rd_address;
  logic        register_write_en;
  logic [31:0] register_write_data;

  iterative_div_unit #(
    .DATA_WIDTH(32),
    .CNT_W     (6)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .kill               (kill),
    .div_op             (div_op),
    .dividend           (dividend),
    .divisor            (divisor),
    .rd_in              (rd_in),
    .busy               (busy),
    .done               (done),
    .rd_address         (rd_address),
    .register_write_en  (register_write_en),
    .register_write_data(register_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data",    register_write_data, e.data);
        check("wb_rd",      {27'd0, rd_address}, {27'd0, e.rd});
        check("wb_en",      {31'd0, register_write_en}, {31'd0, e.we});
        check("done_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Advance n clock edges, then step 1 time unit past the last edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one sampling edge. Call it 1 time unit
  // after a rising edge. With push set, it queues the expected result.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp_data,
                       input int lat);
    exp_t e;
    start    = 1'b1;
    div_op   = op;
    dividend = a;
    divisor  = b;
    rd_in    = rd;
    if (push) begin
      e.data   = exp_data;
      e.rd     = rd;
      e.we     = (rd != 5'd0);
      e.at_cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int   n;
    exp_t e;
    rst      = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    div_op   = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    rd_in    = 5'd0;

    // ---- Reset state -------------------------------------------------------
    wait_cyc(2);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we",   {31'd0, register_write_en}, 32'd0);
    check("rst_rd",   {27'd0, rd_address}, 32'd0);
    check("rst_data", register_write_data, 32'd0);
    rst = 1'b1;
    wait_cyc(1);

    // ---- DIVU / REMU 100/7 with busy-duration check ------------------------
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, LAT_NORMAL);
    n = 0;
    while (busy && n < 40) begin
      n++;
      wait_cyc(1);
    end
    check("divu_busy_cycles", n, 33);
    issue(OP_REMU, 32'd100, 32'd7, 5'd5, 1'b1, 32'd2, LAT_NORMAL);
    wait_cyc(34);

    // ---- Signed divide / remainder -----------------------------------------
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFD, LAT_NORMAL);  // -7/2 = -3
    wait_cyc(34);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFF, LAT_NORMAL);  // -7%2 = -1
    wait_cyc(34);
    issue(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 1'b1, 32'd1, LAT_NORMAL);          // 7%-2 = 1
    wait_cyc(34);

    // ---- Special cases: done one cycle after the start edge ----------------
    issue(OP_DIV, 32'd5, 32'd0, 5'd1, 1'b1, 32'hFFFF_FFFF, LAT_SPECIAL);
    wait_cyc(2);
    issue(OP_REM, 32'd5, 32'd0, 5'd2, 1'b1, 32'd5, LAT_SPECIAL);
    wait_cyc(2);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h8000_0000, LAT_SPECIAL);
    wait_cyc(2);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'd0, LAT_SPECIAL);
    wait_cyc(2);

    // ---- start held high: one op accepted every 34 cycles ------------------
    start    = 1'b1;
    div_op   = OP_DIV;
    dividend = 32'd1000;
    divisor  = 32'hFFFF_FFFD;  // -3 ; 1000 / -3 = -333
    rd_in    = 5'd10;
    e.data = 32'hFFFF_FEB3; e.rd = 5'd10; e.we = 1'b1; e.at_cyc = cyc + 1 + LAT_NORMAL;
    sb.push_back(e);
    e.at_cyc = cyc + 1 + 34 + LAT_NORMAL;
    sb.push_back(e);
    wait_cyc(40);
    start = 1'b0;
    wait_cyc(35);

    // ---- start pulse while busy is ignored; operands not re-latched --------
    issue(OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd3, 1'b1, 32'd5, LAT_NORMAL);
    wait_cyc(10);
    issue(OP_DIVU, 32'd1, 32'd1, 5'd7, 1'b0, 32'd0, 0);
    wait_cyc(30);

    // ---- rd = 0: done pulses, no write enable ------------------------------
    issue(OP_DIVU, 32'd9, 32'd3, 5'd0, 1'b1, 32'd3, LAT_NORMAL);
    wait_cyc(34);

    // ---- kill in CALC, kill beating start, kill in DONE --------------------
    issue(OP_DIVU, 32'd50, 32'd5, 5'd9, 1'b0, 32'd0, 0);
    wait_cyc(9);
    kill = 1'b1;
    wait_cyc(1);
    kill = 1'b0;
    check("kill_calc_idle", {31'd0, busy}, 32'd0);
    kill = 1'b1;
    issue(OP_DIVU, 32'd50, 32'd5, 5'd9, 1'b0, 32'd0, 0);
    kill = 1'b0;
    check("kill_beats_start", {31'd0, busy}, 32'd0);
    wait_cyc(1);

    issue(OP_DIVU, 32'd50, 32'd5, 5'd9, 1'b0, 32'd0, 0);
    wait_cyc(32);                       // now in the DONE cycle
    kill = 1'b1;
    #1;
    check("kill_done_busy", {31'd0, busy}, 32'd1);
    check("kill_done_we",   {31'd0, register_write_en}, 32'd0);
    wait_cyc(1);
    kill = 1'b0;
    check("kill_done_idle", {31'd0, busy}, 32'd0);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd12, 1'b1, 32'hFFFF_FFFF, LAT_NORMAL);
    wait_cyc(34);

    // ---- asynchronous reset mid-CALC ---------------------------------------
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, 32'd0, 0);
    wait_cyc(10);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_we",   {31'd0, register_write_en}, 32'd0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(40);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
